// File: rtl/multi_ff_pkg.sv
// multi_ff_bank shared definitions
// mode encodings, SR policy codes, per-bit next-state function
package multi_ff_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'd0,
    MODE_JK = 2'd1,
    MODE_D  = 2'd2,
    MODE_T  = 2'd3
  } mode_e;

  localparam int SR_HOLD  = 0;
  localparam int SR_SET   = 1;
  localparam int SR_RESET = 2;

  // next state of one bit; b is ignored in D and T modes
  function automatic logic ff_next(
    input mode_e mode,
    input logic  a,
    input logic  b,
    input logic  q,
    input int    policy
  );
    logic n;
    n = q;
    case (mode)
      MODE_SR: begin
        case ({a, b})
          2'b10:   n = 1'b1;
          2'b01:   n = 1'b0;
          2'b11: begin
            if (policy == SR_SET)
              n = 1'b1;
            else if (policy == SR_RESET)
              n = 1'b0;
            else
              n = q;
          end
          default: n = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   n = 1'b1;
          2'b01:   n = 1'b0;
          2'b11:   n = ~q;
          default: n = q;
        endcase
      end
      MODE_D:  n = a;
      MODE_T:  n = q ^ a;
      default: n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/multi_ff_bank_cell.sv
// single flip-flop bit of the bank
// async reset, sync clear, enable, runtime mode
import multi_ff_pkg::*;

module ff_bit_cell #(
  parameter logic RESET_BIT      = 1'b0,
  parameter int   SR_BOTH_POLICY = SR_HOLD
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  clr,
  input  mode_e mode,
  input  logic  a,
  input  logic  b,
  output logic  q
);

  logic r_q;
  logic w_nxt;

  // next-state decode for the selected mode
  always_comb begin
    w_nxt = ff_next(mode, a, b, r_q, SR_BOTH_POLICY);
  end

  // state register: reset > clr > en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= RESET_BIT;
    else if (clr)
      r_q <= RESET_BIT;
    else if (en)
      r_q <= w_nxt;
  end

  assign q = r_q;

endmodule

// File: rtl/multi_ff_bank.sv
// WIDTH-bit flip-flop bank with shared mode
// plus registered forbidden-SR flag and saturating counter
import multi_ff_pkg::*;

module multi_ff_bank #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter int               SR_BOTH_POLICY = 0,
  parameter int               CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  mode_e            w_mode;
  logic [WIDTH-1:0] w_q;
  logic             w_evt;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  assign w_mode = mode_e'(mode);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    ff_bit_cell #(
      .RESET_BIT      (RESET_VAL[gi]),
      .SR_BOTH_POLICY (SR_BOTH_POLICY)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (clr),
      .mode  (w_mode),
      .a     (a[gi]),
      .b     (b[gi]),
      .q     (w_q[gi])
    );
  end

  // one forbidden event per cycle, however many bits collide
  always_comb begin
    w_evt = en && !clr &&
            (w_mode == MODE_SR) &&
            (|(a & b));
  end

  // flag is high only for the cycle after an event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_illegal <= 1'b0;
    else
      r_illegal <= w_evt;
  end

  // saturating counter; a clear that meets an event lands on 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (cnt_clr)
      r_cnt <= w_evt ? CNT_W'(1) : '0;
    else if (w_evt && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign q           = w_q;
  assign q_bar       = ~w_q;
  assign illegal     = r_illegal;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_multi_ff_bank.sv
// scoreboard bench for multi_ff_bank
// WIDTH=4, CNT_W=2, three SR policies side by side
module tb_multi_ff_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [3:0] a;
  logic [3:0] b;
  logic       cnt_clr;

  logic [3:0] q,  qb;
  logic       ill;
  logic [1:0] cnt;
  logic [3:0] q1, qb1;
  logic       ill1;
  logic [1:0] cnt1;
  logic [3:0] q2, qb2;
  logic       ill2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       cc;
    logic [3:0] eq;
    logic       eill;
    logic [1:0] ecnt;
  } row_t;

  typedef struct packed {
    logic [3:0] q;
    logic       ill;
    logic [1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [3:0] q1;
    logic [3:0] q2;
    logic       ill;
    logic [1:0] cnt;
  } pexp_t;

  exp_t  sb  [$];
  pexp_t psb [$];

  localparam logic [1:0] SR = 2'd0;
  localparam logic [1:0] JK = 2'd1;
  localparam logic [1:0] DM = 2'd2;
  localparam logic [1:0] TM = 2'd3;

  multi_ff_bank #(
    .WIDTH(4), .RESET_VAL(4'b0000),
    .SR_BOTH_POLICY(0), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .mode(mode), .a(a), .b(b), .cnt_clr(cnt_clr),
    .q(q), .q_bar(qb), .illegal(ill), .illegal_cnt(cnt)
  );

  multi_ff_bank #(
    .WIDTH(4), .RESET_VAL(4'b0000),
    .SR_BOTH_POLICY(1), .CNT_W(2)
  ) dut_p1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .mode(mode), .a(a), .b(b), .cnt_clr(cnt_clr),
    .q(q1), .q_bar(qb1), .illegal(ill1), .illegal_cnt(cnt1)
  );

  multi_ff_bank #(
    .WIDTH(4), .RESET_VAL(4'b0000),
    .SR_BOTH_POLICY(2), .CNT_W(2)
  ) dut_p2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .mode(mode), .a(a), .b(b), .cnt_clr(cnt_clr),
    .q(q2), .q_bar(qb2), .illegal(ill2), .illegal_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive on the falling edge, return 1ns after the rising edge
  task automatic apply(input row_t r);
    @(negedge clk);
    en      = r.en;
    clr     = r.clr;
    mode    = r.mode;
    a       = r.a;
    b       = r.b;
    cnt_clr = r.cc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t t [5];
    exp_t e;
    checks++;
    if (q !== 4'b0000 || qb !== 4'b1111 ||
        ill !== 1'b0 || cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_init: q=%b qb=%b ill=%b cnt=%0d need 0000/1111/0/0",
               q, qb, ill, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t[0] = '{1'b1, 1'b0, SR, 4'b0001, 4'b0001, 1'b0,
             4'b0000, 1'b1, 2'd1};
    t[1] = '{1'b1, 1'b0, DM, 4'b1010, 4'b0000, 1'b0,
             4'b1010, 1'b0, 2'd1};
    foreach (t[i]) begin
      if (i > 1) break;
      sb.push_back(exp_t'{t[i].eq, t[i].eill, t[i].ecnt});
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || qb !== ~e.q ||
          ill !== e.ill || cnt !== e.cnt) begin
        errors++;
        $display("FAIL reset_pre[%0d]: q=%b qb=%b ill=%b cnt=%0d need q=%b ill=%b cnt=%0d",
                 i, q, qb, ill, cnt, e.q, e.ill, e.cnt);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 4'b0000 || qb !== 4'b1111 ||
        ill !== 1'b0 || cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: q=%b qb=%b ill=%b cnt=%0d need 0000/1111/0/0",
               q, qb, ill, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t[2] = '{1'b1, 1'b1, DM, 4'b1111, 4'b0000, 1'b0,
             4'b0000, 1'b0, 2'd0};
    t[3] = '{1'b1, 1'b0, DM, 4'b0110, 4'b0000, 1'b0,
             4'b0110, 1'b0, 2'd0};
    t[4] = '{1'b1, 1'b1, SR, 4'b1111, 4'b1111, 1'b0,
             4'b0000, 1'b0, 2'd0};
    for (int i = 2; i < 5; i++) begin
      sb.push_back(exp_t'{t[i].eq, t[i].eill, t[i].ecnt});
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || qb !== ~e.q ||
          ill !== e.ill || cnt !== e.cnt) begin
        errors++;
        $display("FAIL clear[%0d]: q=%b qb=%b ill=%b cnt=%0d need q=%b ill=%b cnt=%0d",
                 i, q, qb, ill, cnt, e.q, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_sr();
    row_t t [5];
    exp_t e;
    t[0] = '{1'b1, 1'b0, SR, 4'b0011, 4'b0000, 1'b0,
             4'b0011, 1'b0, 2'd0};
    t[1] = '{1'b1, 1'b0, SR, 4'b0000, 4'b0001, 1'b0,
             4'b0010, 1'b0, 2'd0};
    t[2] = '{1'b1, 1'b0, SR, 4'b0100, 4'b0100, 1'b0,
             4'b0010, 1'b1, 2'd1};
    t[3] = '{1'b0, 1'b0, SR, 4'b0100, 4'b0100, 1'b0,
             4'b0010, 1'b0, 2'd1};
    t[4] = '{1'b1, 1'b0, SR, 4'b0000, 4'b0000, 1'b0,
             4'b0010, 1'b0, 2'd1};
    foreach (t[i]) begin
      sb.push_back(exp_t'{t[i].eq, t[i].eill, t[i].ecnt});
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || qb !== ~e.q ||
          ill !== e.ill || cnt !== e.cnt) begin
        errors++;
        $display("FAIL sr[%0d]: q=%b qb=%b ill=%b cnt=%0d need q=%b ill=%b cnt=%0d",
                 i, q, qb, ill, cnt, e.q, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_jk_t();
    row_t t [9];
    exp_t e;
    t[0] = '{1'b1, 1'b0, DM, 4'b0000, 4'b0000, 1'b0,
             4'b0000, 1'b0, 2'd1};
    t[1] = '{1'b1, 1'b0, JK, 4'b1111, 4'b1111, 1'b0,
             4'b1111, 1'b0, 2'd1};
    t[2] = '{1'b1, 1'b0, JK, 4'b1111, 4'b1111, 1'b0,
             4'b0000, 1'b0, 2'd1};
    t[3] = '{1'b1, 1'b0, TM, 4'b0101, 4'b0000, 1'b0,
             4'b0101, 1'b0, 2'd1};
    t[4] = '{1'b1, 1'b0, TM, 4'b0101, 4'b0000, 1'b0,
             4'b0000, 1'b0, 2'd1};
    t[5] = '{1'b0, 1'b0, TM, 4'b0101, 4'b0000, 1'b0,
             4'b0000, 1'b0, 2'd1};
    t[6] = '{1'b1, 1'b0, JK, 4'b1100, 4'b0000, 1'b0,
             4'b1100, 1'b0, 2'd1};
    t[7] = '{1'b1, 1'b0, JK, 4'b0000, 4'b0100, 1'b0,
             4'b1000, 1'b0, 2'd1};
    t[8] = '{1'b1, 1'b0, JK, 4'b0000, 4'b0000, 1'b0,
             4'b1000, 1'b0, 2'd1};
    foreach (t[i]) begin
      sb.push_back(exp_t'{t[i].eq, t[i].eill, t[i].ecnt});
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || qb !== ~e.q ||
          ill !== e.ill || cnt !== e.cnt) begin
        errors++;
        $display("FAIL jk_t[%0d]: q=%b qb=%b ill=%b cnt=%0d need q=%b ill=%b cnt=%0d",
                 i, q, qb, ill, cnt, e.q, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_d_switch();
    row_t t [4];
    exp_t e;
    t[0] = '{1'b1, 1'b0, DM, 4'b1001, 4'b0000, 1'b0,
             4'b1001, 1'b0, 2'd1};
    t[1] = '{1'b1, 1'b0, SR, 4'b0000, 4'b1000, 1'b0,
             4'b0001, 1'b0, 2'd1};
    t[2] = '{1'b1, 1'b0, TM, 4'b0001, 4'b1111, 1'b0,
             4'b0000, 1'b0, 2'd1};
    t[3] = '{1'b1, 1'b0, DM, 4'b0110, 4'b1111, 1'b0,
             4'b0110, 1'b0, 2'd1};
    foreach (t[i]) begin
      sb.push_back(exp_t'{t[i].eq, t[i].eill, t[i].ecnt});
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || qb !== ~e.q ||
          ill !== e.ill || cnt !== e.cnt) begin
        errors++;
        $display("FAIL d_switch[%0d]: q=%b qb=%b ill=%b cnt=%0d need q=%b ill=%b cnt=%0d",
                 i, q, qb, ill, cnt, e.q, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_counter();
    row_t t [8];
    exp_t e;
    t[0] = '{1'b1, 1'b0, DM, 4'b0000, 4'b0000, 1'b1,
             4'b0000, 1'b0, 2'd0};
    t[1] = '{1'b1, 1'b0, SR, 4'b0001, 4'b0001, 1'b0,
             4'b0000, 1'b1, 2'd1};
    t[2] = '{1'b1, 1'b0, SR, 4'b0011, 4'b0011, 1'b0,
             4'b0000, 1'b1, 2'd2};
    t[3] = '{1'b1, 1'b0, SR, 4'b1000, 4'b1000, 1'b0,
             4'b0000, 1'b1, 2'd3};
    t[4] = '{1'b1, 1'b0, SR, 4'b1111, 4'b1111, 1'b0,
             4'b0000, 1'b1, 2'd3};
    t[5] = '{1'b1, 1'b0, SR, 4'b0100, 4'b0100, 1'b1,
             4'b0000, 1'b1, 2'd1};
    t[6] = '{1'b0, 1'b0, SR, 4'b0000, 4'b0000, 1'b1,
             4'b0000, 1'b0, 2'd0};
    t[7] = '{1'b1, 1'b0, SR, 4'b0010, 4'b0000, 1'b1,
             4'b0010, 1'b0, 2'd0};
    foreach (t[i]) begin
      sb.push_back(exp_t'{t[i].eq, t[i].eill, t[i].ecnt});
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || qb !== ~e.q ||
          ill !== e.ill || cnt !== e.cnt) begin
        errors++;
        $display("FAIL counter[%0d]: q=%b qb=%b ill=%b cnt=%0d need q=%b ill=%b cnt=%0d",
                 i, q, qb, ill, cnt, e.q, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_policy();
    row_t  t [4];
    pexp_t e;
    pexp_t p [4];
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    t[0] = '{1'b1, 1'b0, SR, 4'b1111, 4'b1111, 1'b0,
             4'b0000, 1'b1, 2'd1};
    t[1] = '{1'b1, 1'b0, DM, 4'b1111, 4'b0000, 1'b0,
             4'b0000, 1'b0, 2'd1};
    t[2] = '{1'b1, 1'b0, SR, 4'b0110, 4'b0110, 1'b0,
             4'b0000, 1'b1, 2'd2};
    t[3] = '{1'b1, 1'b0, SR, 4'b1111, 4'b1111, 1'b0,
             4'b0000, 1'b1, 2'd3};
    p[0] = '{4'b1111, 4'b0000, 1'b1, 2'd1};
    p[1] = '{4'b1111, 4'b1111, 1'b0, 2'd1};
    p[2] = '{4'b1111, 4'b1001, 1'b1, 2'd2};
    p[3] = '{4'b1111, 4'b0000, 1'b1, 2'd3};
    foreach (t[i]) begin
      psb.push_back(p[i]);
      apply(t[i]);
      e = psb.pop_front();
      checks++;
      if (q1 !== e.q1 || qb1 !== ~e.q1 ||
          ill1 !== e.ill || cnt1 !== e.cnt) begin
        errors++;
        $display("FAIL policy1[%0d]: q=%b qb=%b ill=%b cnt=%0d need q=%b ill=%b cnt=%0d",
                 i, q1, qb1, ill1, cnt1, e.q1, e.ill, e.cnt);
      end
      checks++;
      if (q2 !== e.q2 || qb2 !== ~e.q2 ||
          ill2 !== e.ill || cnt2 !== e.cnt) begin
        errors++;
        $display("FAIL policy2[%0d]: q=%b qb=%b ill=%b cnt=%0d need q=%b ill=%b cnt=%0d",
                 i, q2, qb2, ill2, cnt2, e.q2, e.ill, e.cnt);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    mode    = 2'd0;
    a       = 4'b0000;
    b       = 4'b0000;
    cnt_clr = 1'b0;
    #12;
    test_reset();
    test_sr();
    test_jk_t();
    test_d_switch();
    test_counter();
    test_policy();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_ff_bank.md
Name: multi_ff_bank

Overview:
- Parametrised bank of WIDTH flip-flops. All bits share a runtime mode: SR, JK, D or T.
- Successor to the single-bit SR flip-flop. Adds:
  - width generalisation
  - mode select
  - async reset and synchronous clear
  - enable
  - registered detection and counting of forbidden SR inputs
- Used as a general state/flag register wherever per-bit set/reset/toggle control is needed.

Parameters:
WIDTH, 8, number of flip-flop bits
RESET_VAL, 0 (WIDTH bits), q value after reset or clr
SR_BOTH_POLICY, 0, SR-mode action on S=R=1: 0 hold, 1 set, 2 reset
CNT_W, 8, width of saturating illegal-event counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  update enable; 0 = hold all bits
clr  input  1  synchronous clear of q to RESET_VAL
mode  input  2  0 SR, 1 JK, 2 D, 3 T
a  input  WIDTH  S / J / D / T per bit
b  input  WIDTH  R / K per bit; ignored in D and T modes
cnt_clr  input  1  synchronous clear of illegal_cnt
q  output  WIDTH  flip-flop state
q_bar  output  WIDTH  always ~q, including during reset
illegal  output  1  registered flag, one cycle per forbidden SR cycle
illegal_cnt  output  CNT_W  saturating count of forbidden SR cycles

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): q=RESET_VAL, q_bar=~RESET_VAL, illegal=0, illegal_cnt=0.
- Release of rst_n is synchronous to clk; the first update occurs on the first rising edge with rst_n=1.
- Priority per edge: rst_n > clr > en.
  - clr=1: q<=RESET_VAL regardless of en and mode; illegal<=0; no event counted.
  - en=0 (clr=0): q holds; illegal<=0; no event counted.
- Per-bit next state when en=1, clr=0:
  - SR: a=1,b=0 -> 1; a=0,b=1 -> 0; 00 -> hold; 11 -> per SR_BOTH_POLICY (hold/set/reset).
  - JK: 00 hold, 10 set, 01 reset, 11 toggle.
  - D: q<=a.
  - T: a=1 toggle, a=0 hold.
- mode is sampled each edge. A mode change takes effect at that edge with no loss of current q. Values 0-3 are all legal.
- Forbidden event: en=1, clr=0, mode=SR, and any bit has a=b=1.
  - Counts once per cycle, not once per bit.
  - illegal<=1 on the edge that samples the event, so it is visible in the following cycle. It is 0 on every other edge.
- illegal_cnt:
  - +1 per forbidden event; saturates at all-ones and holds there.
  - cnt_clr=1 without an event in the same cycle -> 0.
  - cnt_clr=1 together with an event -> 1.
  - cnt_clr does not affect q or illegal.
- Latency: q, q_bar, illegal and illegal_cnt all update on the same edge that samples the inputs. No combinational path from inputs to outputs.
- q_bar is derived as ~q; it is not a separate register.

Decomposition:
- Package multi_ff_pkg:
  - mode encodings MODE_SR=2'd0, MODE_JK=2'd1, MODE_D=2'd2, MODE_T=2'd3
  - SR policy constants SR_HOLD=0, SR_SET=1, SR_RESET=2
  - function ff_next(mode, a, b, q, policy) returning 1-bit next state
- Sub-module ff_bit_cell: one flip-flop bit with async reset, clr, en and next-state logic, generated WIDTH times.
- Illegal detection and the counter live in the top module.

Test Plan (WIDTH=4, RESET_VAL=4'b0000, SR_BOTH_POLICY=0, CNT_W=2):
1. Reset/clear:
   - Assert rst_n=0 mid-cycle with q=4'b1010 -> q=0000 and q_bar=1111 immediately, illegal=0, cnt=0.
   - clr=1 with en=1, D mode, a=1111 -> q stays 0000.
2. SR mode:
   - a=0011,b=0000 -> q=0011; then a=0000,b=0001 -> q=0010.
   - Then a=0100,b=0100 -> q holds 0010, illegal=1 next cycle, cnt=1.
   - Repeat with en=0 -> no change, cnt stays 1.
3. JK/T modes:
   - JK from q=0000 with a=1111,b=1111 twice -> q=1111 then 0000.
   - Switch to T mode, a=0101 -> q=0101; a=0101 again -> q=0000.
   - Repeat under en=0 -> q holds.
4. D and mode switch:
   - D mode a=1001 -> q=1001.
   - Same edge-sequence switch to SR with a=0000,b=1000 -> q=0001. q_bar always equals ~q.
5. Counter:
   - Four consecutive forbidden SR cycles -> cnt 1,2,3,3 (saturated).
   - cnt_clr with a concurrent forbidden cycle -> cnt=1.
   - cnt_clr alone -> cnt=0.
6. Policy sweep:
   - Rebuild with SR_BOTH_POLICY=1, then 2. From q=0000, a=b=1111 -> q=1111 (policy 1) or stays 0000 (policy 2); illegal=1 in both cases.
